// File: rtl/dispense_motor_arbiter.sv
// rtl/dispense_motor_arbiter.sv - round-robin motor driver arbiter with jam timeout, cooldown and sticky faults
module dispense_motor_arbiter #(
  parameter int RUN_TICKS = 8,
  parameter int GAP_TICKS = 2,
  parameter int CW        = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TICK,
  input  logic [2:0] REQ,
  input  logic       PROD,
  input  logic       CLR,
  output logic [2:0] GNT,
  output logic [2:0] MOT,
  output logic [2:0] ACK,
  output logic [2:0] FLT,
  output logic       BUSY,
  output logic [1:0] ST
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_GAP  = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  localparam logic [CW-1:0] RUN_LAST = CW'(RUN_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_TICKS - 1);

  state_t        st_q, st_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [2:0]    ack_q, ack_d;
  logic [2:0]    flt_q, flt_d;
  logic [2:0]    cur_q, cur_d;    // one-hot channel of the vend in progress
  logic [2:0]    last_q, last_d;  // one-hot channel served most recently
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [2:0]    elig;
  logic [2:0]    pick;

  assign elig = REQ & ~flt_q;

  // Round-robin pick: first eligible channel after the one served last.
  always_comb begin
    pick = 3'b000;
    case (last_q)
      3'b001: begin
        if      (elig[1]) pick = 3'b010;
        else if (elig[2]) pick = 3'b100;
        else if (elig[0]) pick = 3'b001;
      end
      3'b010: begin
        if      (elig[2]) pick = 3'b100;
        else if (elig[0]) pick = 3'b001;
        else if (elig[1]) pick = 3'b010;
      end
      default: begin
        if      (elig[0]) pick = 3'b001;
        else if (elig[1]) pick = 3'b010;
        else if (elig[2]) pick = 3'b100;
      end
    endcase
  end

  // Next-state and next-output logic; a fault set on the same edge as CLR survives.
  always_comb begin
    st_d   = st_q;
    gnt_d  = gnt_q;
    ack_d  = 3'b000;
    cnt_d  = cnt_q;
    cur_d  = cur_q;
    last_d = last_q;
    flt_d  = CLR ? 3'b000 : flt_q;
    case (st_q)
      S_IDLE: begin
        if (pick != 3'b000) begin
          gnt_d = pick;
          cur_d = pick;
          cnt_d = '0;
          st_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (PROD) begin
          ack_d = cur_q;
          gnt_d = 3'b000;
          cnt_d = '0;
          st_d  = S_GAP;
        end else if (TICK) begin
          if (cnt_q == RUN_LAST) begin
            flt_d = flt_d | cur_q;
            gnt_d = 3'b000;
            cnt_d = '0;
            st_d  = S_GAP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_GAP: begin
        if (TICK) begin
          if (cnt_q == GAP_LAST) begin
            last_d = cur_q;
            cnt_d  = '0;
            st_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        gnt_d = 3'b000;
        cnt_d = '0;
        st_d  = S_IDLE;
      end
    endcase
    busy_d = (st_d == S_RUN) || (st_d == S_GAP);
  end

  // State and output registers; reset drops the motor without waiting for a clock.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      st_q   <= S_IDLE;
      gnt_q  <= 3'b000;
      ack_q  <= 3'b000;
      flt_q  <= 3'b000;
      cur_q  <= 3'b000;
      last_q <= 3'b100;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      gnt_q  <= gnt_d;
      ack_q  <= ack_d;
      flt_q  <= flt_d;
      cur_q  <= cur_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign GNT  = gnt_q;
  assign MOT  = gnt_q;
  assign ACK  = ack_q;
  assign FLT  = flt_q;
  assign BUSY = busy_q;
  assign ST   = st_q;

endmodule
